set_mode_controller: RTL and testbench
======================================

# set_mode_controller

Front-panel sequencer for the alarm clock. It turns debounced button pulses into the display mode select `S` and the field-cursor select `CW`. When the user edits a field, it performs the increment arithmetic and issues single-cycle write strobes to the time register and the alarm register. It sits between the button debouncers and the display/time-keeping datapath, and is the only writer of those registers other than the time counter itself.

## Interface
- `TIMEOUT_TICKS`, default 10: number of `Tick` pulses with no button activity before any non-RUN state falls back to RUN.
- `Clk` in 1: system clock; all state changes on the rising edge.
- `Clr` in 1: asynchronous, active-low reset.
- `Tick` in 1: one-cycle pulse per second, used only for the timeout.
- `BtnMode`, `BtnNext`, `BtnInc`, `BtnAlarm` in 1 each: one-cycle, already-debounced press pulses.
- `CT` in 15: current time, as {day[2:0] 0–6, hour[4:0] binary 0–23, min_tens[2:0] BCD, min_units[3:0] BCD}.
- `ST` in 16: stored alarm, as {en, day[2:0], hour[4:0], min_tens[2:0], min_units[3:0]}.
- `S` out 2: display mode.
  - 00 = RUN (show time).
  - 01 = SET_T (edit time).
  - 10 = VIEW_A (show alarm).
  - 11 = SET_A (edit alarm).
  - `S[1]` = alarm selected.
- `CW` out 2: field cursor.
  - 00 = none.
  - 01 = minutes.
  - 10 = hours.
  - 11 = day.
- `TLoad` out 1, `TData` out 15: time-register write strobe and value.
- `ALoad` out 1, `AData` out 16: alarm-register write strobe and value.

## Operation
- **Mode sequence.** States are RUN, SET_T, VIEW_A, SET_A. Each `BtnMode` pulse advances RUN→SET_T→VIEW_A→SET_A→RUN.
- **Cursor.**
  - Entering SET_T or SET_A sets `CW`=01.
  - Entering RUN or VIEW_A sets `CW`=00.
  - In SET_T or SET_A, `BtnNext` cycles 01→10→11→01. In other states `BtnNext` is ignored.
- **Increment in SET_T.** `BtnInc` samples `CT`, increments the field selected by `CW`, drives the result on `TData`, and pulses `TLoad`.
- **Increment in SET_A.** `BtnInc` does the same on `ST`. `AData[15]` carries `ST[15]` unchanged. `ALoad` pulses.
- **Field increment rules.** Only the selected field changes; other fields pass through bit-exact. There is no carry between fields.
  - Minutes: units 9→0 carries into tens; 59→00.
  - Hours: 23→0.
  - Day: 6→0.
  - Out-of-range input (min_tens>5, min_units>9, hour>23, day=7): the field increments to 0.
- **Alarm enable.** In RUN or VIEW_A, `BtnAlarm` gives `AData`=`ST` with bit 15 inverted, and pulses `ALoad`. In SET_T and SET_A, `BtnAlarm` is ignored.
- **Same-cycle priority.** `BtnMode` > `BtnNext` > `BtnInc` > `BtnAlarm`. Lower-priority pulses in that cycle are dropped.
- **Timeout.**
  - The timeout counter clears on any button pulse and on any state change.
  - It counts `Tick` pulses only in non-RUN states.
  - When the counter reaches `TIMEOUT_TICKS`, the block goes to RUN with `CW`=00 and the counter clears.
  - A button pulse in the same cycle as the terminal `Tick` wins: the timeout does not fire.
- **Reset values.** State RUN, `S`=00, `CW`=00, `TLoad`=0, `ALoad`=0, `TData`=0, `AData`=0, counter=0.
- **Reset mid-operation.** `Clr` low forces the reset values immediately. A strobe in flight is aborted.

## Timing
- All outputs are registered.
- `S` and `CW` change on the first rising edge after the cycle in which the button pulse is high.
- `TLoad`/`ALoad` are high for exactly one cycle: the cycle after the `BtnInc`/`BtnAlarm` pulse. `TData`/`AData` are valid in that same cycle and hold their value afterwards.
- The time register must give `TLoad` priority over its own minute advance in the same cycle. `CT` is sampled in the button cycle, so an edit that coincides with a minute rollover loses the rollover. This is accepted.
- Back-to-back `BtnInc` on consecutive cycles gives consecutive strobes. Each strobe is based on `CT`/`ST` as sampled in its own cycle, so the registers must update within one cycle.
- The timeout fires on the edge after the `TIMEOUT_TICKS`-th `Tick`.

## Structure
- **Shared package `clock_pkg`:**
  - state encoding (which equals the `S` codes);
  - `CW` field codes;
  - bit-position constants for the day, hour and minute fields of `CT`/`ST`;
  - the `ST` enable bit index.
- **Sub-module `field_incrementer`:** combinational. Inputs are a 15-bit value and a 2-bit field code; output is the incremented value, applying the wrap and out-of-range rules. One instance serves both time and alarm editing through an input mux on `S[1]`.
- **Controller proper:** state register, cursor register, timeout counter, output registers.

## Test plan
- **Reset, then mode cycling.** Release `Clr`, then four `BtnMode` pulses → `S` steps 01, 10, 11, 00 and `CW` steps 01, 00, 01, 00; no strobes.
- **Minute wrap.** In SET_T with `CT`={day 3, hour 13, min 59}, `BtnInc` → one-cycle `TLoad` with `TData`={3, 13, 00}. Repeat with min 09 → `TData` min 10.
- **Hour and day wrap.** Set `CW`=10 with hour 23, `BtnInc` → hour 0. Then `CW`=11 with day 6, `BtnInc` → day 0. Other fields are unchanged in both cases.
- **Alarm enable toggle.** In RUN with `ST`=16'h0000, `BtnAlarm` → `ALoad` pulse with `AData`=16'h8000. In SET_A, `BtnAlarm` → no `ALoad`.
- **Timeout.** With `TIMEOUT_TICKS`=3 in VIEW_A, three `Tick`s → RUN on the next edge. A `BtnNext` on the third `Tick` cycle → still VIEW_A.
- **Reset and priority.** Assert `Clr` in the cycle after `BtnInc` → `TLoad` stays 0 and all outputs are at reset values. `BtnMode` and `BtnInc` in the same cycle in SET_T → mode advances and there is no `TLoad`.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the alarm-clock front panel: mode and cursor codes,
// and the bit layout of the time/alarm words.
package clock_pkg;

  // Mode encoding doubles as the S display-select code; bit 1 means "alarm selected".
  typedef enum logic [1:0] {
    MODE_RUN    = 2'b00,
    MODE_SET_T  = 2'b01,
    MODE_VIEW_A = 2'b10,
    MODE_SET_A  = 2'b11
  } mode_e;

  // Field cursor codes as driven on CW.
  typedef enum logic [1:0] {
    CW_NONE = 2'b00,
    CW_MIN  = 2'b01,
    CW_HOUR = 2'b10,
    CW_DAY  = 2'b11
  } cw_e;

  // Bit positions within the 15-bit time word (and low 15 bits of the alarm word).
  localparam int MIN_U_LSB    = 0;
  localparam int MIN_U_MSB    = 3;
  localparam int MIN_T_LSB    = 4;
  localparam int MIN_T_MSB    = 6;
  localparam int HOUR_LSB     = 7;
  localparam int HOUR_MSB     = 11;
  localparam int DAY_LSB      = 12;
  localparam int DAY_MSB      = 14;
  localparam int ALARM_EN_BIT = 15;

  // Mode sequence followed on each mode button press.
  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_RUN:    return MODE_SET_T;
      MODE_SET_T:  return MODE_VIEW_A;
      MODE_VIEW_A: return MODE_SET_A;
      MODE_SET_A:  return MODE_RUN;
      default:     return MODE_RUN;
    endcase
  endfunction

  // Cursor rotation minutes -> hours -> day -> minutes.
  function automatic cw_e next_cursor(input cw_e c);
    case (c)
      CW_MIN:  return CW_HOUR;
      CW_HOUR: return CW_DAY;
      CW_DAY:  return CW_MIN;
      default: return CW_MIN;
    endcase
  endfunction

  // Both edit modes have bit 0 set.
  function automatic logic is_edit_mode(input mode_e m);
    return m[0];
  endfunction

endpackage

// File: rtl/field_incrementer.sv
// Combinational single-field increment of a time word. Only the selected
// field changes, with no carry into neighbouring fields; out-of-range fields
// restart at zero.
module field_incrementer
  import clock_pkg::*;
(
  input  logic [14:0] value_in,
  input  logic [1:0]  field,
  output logic [14:0] value_out
);

  logic [3:0] min_u_s;
  logic [2:0] min_t_s;
  logic [4:0] hour_s;
  logic [2:0] day_s;

  assign min_u_s = value_in[MIN_U_MSB:MIN_U_LSB];
  assign min_t_s = value_in[MIN_T_MSB:MIN_T_LSB];
  assign hour_s  = value_in[HOUR_MSB:HOUR_LSB];
  assign day_s   = value_in[DAY_MSB:DAY_LSB];

  // Rebuild the word with just the selected field advanced and wrapped.
  always_comb begin
    value_out = value_in;
    case (field)
      2'b01: begin
        if ((min_t_s > 3'd5) || (min_u_s > 4'd9)) begin
          value_out[MIN_T_MSB:MIN_T_LSB] = 3'd0;
          value_out[MIN_U_MSB:MIN_U_LSB] = 4'd0;
        end else if (min_u_s == 4'd9) begin
          value_out[MIN_U_MSB:MIN_U_LSB] = 4'd0;
          value_out[MIN_T_MSB:MIN_T_LSB] = (min_t_s == 3'd5) ? 3'd0 : (min_t_s + 3'd1);
        end else begin
          value_out[MIN_U_MSB:MIN_U_LSB] = min_u_s + 4'd1;
        end
      end
      2'b10: begin
        if (hour_s >= 5'd23) begin
          value_out[HOUR_MSB:HOUR_LSB] = 5'd0;
        end else begin
          value_out[HOUR_MSB:HOUR_LSB] = hour_s + 5'd1;
        end
      end
      2'b11: begin
        if (day_s >= 3'd6) begin
          value_out[DAY_MSB:DAY_LSB] = 3'd0;
        end else begin
          value_out[DAY_MSB:DAY_LSB] = day_s + 3'd1;
        end
      end
      default: begin
        value_out = value_in;
      end
    endcase
  end

endmodule

// File: rtl/set_mode_controller.sv
// Front-panel sequencer: turns button pulses into display mode / cursor
// selects, performs field edits and issues one-cycle register write strobes.
module set_mode_controller
  import clock_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        Tick,
  input  logic        BtnMode,
  input  logic        BtnNext,
  input  logic        BtnInc,
  input  logic        BtnAlarm,
  input  logic [14:0] CT,
  input  logic [15:0] ST,
  output logic [1:0]  S,
  output logic [1:0]  CW,
  output logic        TLoad,
  output logic [14:0] TData,
  output logic        ALoad,
  output logic [15:0] AData
);

  localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);

  mode_e       state_r, state_nx_s;
  cw_e         cw_r, cw_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic        tload_r, tload_nx_s;
  logic        aload_r, aload_nx_s;
  logic [14:0] tdata_r, tdata_nx_s;
  logic [15:0] adata_r, adata_nx_s;
  logic [14:0] inc_in_s, inc_out_s;
  logic        any_btn_s;
  logic        timeout_s;

  // Alarm modes edit ST, time modes edit CT; one incrementer serves both.
  assign inc_in_s = state_r[1] ? ST[14:0] : CT;

  field_incrementer u_inc (
    .value_in  (inc_in_s),
    .field     (cw_r),
    .value_out (inc_out_s)
  );

  assign any_btn_s = BtnMode | BtnNext | BtnInc | BtnAlarm;
  // A button in the terminal Tick cycle suppresses the fallback.
  assign timeout_s = Tick && (state_r != MODE_RUN) && !any_btn_s &&
                     (cnt_r == CNT_W'(TIMEOUT_TICKS - 1));

  // Next-state, cursor, strobe and timeout-counter decisions in button priority order.
  always_comb begin
    state_nx_s = state_r;
    cw_nx_s    = cw_r;
    tload_nx_s = 1'b0;
    aload_nx_s = 1'b0;
    tdata_nx_s = tdata_r;
    adata_nx_s = adata_r;
    if (BtnMode) begin
      state_nx_s = next_mode(state_r);
      if (is_edit_mode(next_mode(state_r))) begin
        cw_nx_s = CW_MIN;
      end else begin
        cw_nx_s = CW_NONE;
      end
    end else if (BtnNext) begin
      if (is_edit_mode(state_r)) begin
        cw_nx_s = next_cursor(cw_r);
      end else begin
        cw_nx_s = cw_r;
      end
    end else if (BtnInc) begin
      case (state_r)
        MODE_SET_T: begin
          tload_nx_s = 1'b1;
          tdata_nx_s = inc_out_s;
        end
        MODE_SET_A: begin
          aload_nx_s = 1'b1;
          adata_nx_s = {ST[ALARM_EN_BIT], inc_out_s};
        end
        default: begin
          tload_nx_s = 1'b0;
        end
      endcase
    end else if (BtnAlarm) begin
      if (!is_edit_mode(state_r)) begin
        aload_nx_s = 1'b1;
        adata_nx_s = ST ^ 16'h8000;
      end else begin
        aload_nx_s = 1'b0;
      end
    end else if (timeout_s) begin
      state_nx_s = MODE_RUN;
      cw_nx_s    = CW_NONE;
    end else begin
      state_nx_s = state_r;
    end

    if (any_btn_s || (state_nx_s != state_r)) begin
      cnt_nx_s = '0;
    end else if (Tick && (state_r != MODE_RUN)) begin
      cnt_nx_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_nx_s = cnt_r;
    end
  end

  // State, cursor, counter and output registers; reset aborts any pending strobe.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_r <= MODE_RUN;
      cw_r    <= CW_NONE;
      cnt_r   <= '0;
      tload_r <= 1'b0;
      aload_r <= 1'b0;
      tdata_r <= 15'd0;
      adata_r <= 16'd0;
    end else begin
      state_r <= state_nx_s;
      cw_r    <= cw_nx_s;
      cnt_r   <= cnt_nx_s;
      tload_r <= tload_nx_s;
      aload_r <= aload_nx_s;
      tdata_r <= tdata_nx_s;
      adata_r <= adata_nx_s;
    end
  end

  assign S     = state_r;
  assign CW    = cw_r;
  assign TLoad = tload_r;
  assign TData = tdata_r;
  assign ALoad = aload_r;
  assign AData = adata_r;

endmodule

// File: tb/tb_set_mode_controller.sv
// Scoreboard bench for set_mode_controller: stimulus pushes expected strobe
// data, a negedge monitor pops and compares whenever a strobe appears.
module tb_set_mode_controller;

  logic        Clk = 1'b0;
  logic        Clr;
  logic        Tick, BtnMode, BtnNext, BtnInc, BtnAlarm;
  logic [14:0] CT;
  logic [15:0] ST;
  logic [1:0]  S, CW;
  logic        TLoad, ALoad;
  logic [14:0] TData;
  logic [15:0] AData;

  int checks = 0;
  int errors = 0;
  logic [14:0] exp_t_q[$];
  logic [15:0] exp_a_q[$];

  set_mode_controller #(.TIMEOUT_TICKS(3)) dut (
    .Clk(Clk), .Clr(Clr), .Tick(Tick),
    .BtnMode(BtnMode), .BtnNext(BtnNext), .BtnInc(BtnInc), .BtnAlarm(BtnAlarm),
    .CT(CT), .ST(ST), .S(S), .CW(CW),
    .TLoad(TLoad), .TData(TData), .ALoad(ALoad), .AData(AData)
  );

  always #5 Clk = ~Clk;

  function automatic logic [14:0] mk_t(input int d, input int h, input int mt, input int mu);
    return {3'(d), 5'(h), 3'(mt), 4'(mu)};
  endfunction

  // Monitor: every strobe seen must match the oldest expected entry.
  always @(negedge Clk) begin
    if (TLoad) begin
      checks++;
      if (exp_t_q.size() == 0) begin
        errors++;
        $display("FAIL tload_unexpected TData=%h", TData);
      end else begin
        logic [14:0] e;
        e = exp_t_q.pop_front();
        if (TData !== e) begin
          errors++;
          $display("FAIL tdata got=%h exp=%h", TData, e);
        end
      end
    end
    if (ALoad) begin
      checks++;
      if (exp_a_q.size() == 0) begin
        errors++;
        $display("FAIL aload_unexpected AData=%h", AData);
      end else begin
        logic [15:0] e;
        e = exp_a_q.pop_front();
        if (AData !== e) begin
          errors++;
          $display("FAIL adata got=%h exp=%h", AData, e);
        end
      end
    end
  end

  // Drive a one-cycle pulse on the buttons in mask {alarm,inc,next,mode} and Tick.
  task automatic press(input logic [3:0] m, input logic tk);
    @(posedge Clk); #1;
    {BtnAlarm, BtnInc, BtnNext, BtnMode} = m;
    Tick = tk;
    @(posedge Clk); #1;
    {BtnAlarm, BtnInc, BtnNext, BtnMode} = 4'b0000;
    Tick = 1'b0;
  endtask

  task automatic check_sc(input string nm, input logic [1:0] es, input logic [1:0] ec);
    @(negedge Clk);
    checks++;
    if (S !== es || CW !== ec) begin
      errors++;
      $display("FAIL %s S=%b CW=%b exp S=%b CW=%b", nm, S, CW, es, ec);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    @(negedge Clk);
    checks++;
    if (S !== 2'b00 || CW !== 2'b00 || TLoad !== 1'b0 || ALoad !== 1'b0 ||
        TData !== 15'd0 || AData !== 16'd0) begin
      errors++;
      $display("FAIL %s S=%b CW=%b TL=%b AL=%b TD=%h AD=%h exp all zero",
               nm, S, CW, TLoad, ALoad, TData, AData);
    end
  endtask

  initial begin
    Clr = 1'b0; Tick = 1'b0;
    BtnMode = 1'b0; BtnNext = 1'b0; BtnInc = 1'b0; BtnAlarm = 1'b0;
    CT = 15'd0; ST = 16'd0;
    repeat (3) @(posedge Clk);
    check_reset_outputs("reset_values");
    Clr = 1'b1;

    // Mode cycling with cursor entry codes
    press(4'b0001, 1'b0); check_sc("mode_set_t", 2'b01, 2'b01);
    press(4'b0001, 1'b0); check_sc("mode_view_a", 2'b10, 2'b00);
    press(4'b0001, 1'b0); check_sc("mode_set_a", 2'b11, 2'b01);
    press(4'b0001, 1'b0); check_sc("mode_run", 2'b00, 2'b00);

    // Minute edits in SET_T
    press(4'b0001, 1'b0);
    CT = mk_t(3, 13, 5, 9); exp_t_q.push_back(mk_t(3, 13, 0, 0)); press(4'b0100, 1'b0);
    CT = mk_t(3, 13, 0, 9); exp_t_q.push_back(mk_t(3, 13, 1, 0)); press(4'b0100, 1'b0);
    // Hour and day wrap
    press(4'b0010, 1'b0); check_sc("cursor_hour", 2'b01, 2'b10);
    CT = mk_t(2, 23, 4, 5); exp_t_q.push_back(mk_t(2, 0, 4, 5)); press(4'b0100, 1'b0);
    press(4'b0010, 1'b0); check_sc("cursor_day", 2'b01, 2'b11);
    CT = mk_t(6, 7, 3, 2); exp_t_q.push_back(mk_t(0, 7, 3, 2)); press(4'b0100, 1'b0);
    press(4'b0010, 1'b0); check_sc("cursor_wrap", 2'b01, 2'b01);
    // Out-of-range minutes restart at zero
    CT = mk_t(1, 5, 6, 3); exp_t_q.push_back(mk_t(1, 5, 0, 0)); press(4'b0100, 1'b0);
    @(negedge Clk); @(negedge Clk);
    checks++;
    if (TData !== mk_t(1, 5, 0, 0)) begin
      errors++;
      $display("FAIL tdata_hold got=%h exp=%h", TData, mk_t(1, 5, 0, 0));
    end

    // Alarm edit in SET_A keeps the enable bit; BtnAlarm is ignored there
    press(4'b0001, 1'b0); press(4'b0001, 1'b0); check_sc("to_set_a", 2'b11, 2'b01);
    ST = {1'b1, 3'd4, 5'd10, 3'd5, 4'd9};
    exp_a_q.push_back({1'b1, 3'd4, 5'd10, 3'd0, 4'd0}); press(4'b0100, 1'b0);
    press(4'b1000, 1'b0);
    // Alarm toggle in RUN
    press(4'b0001, 1'b0); check_sc("back_run", 2'b00, 2'b00);
    ST = 16'h0000; exp_a_q.push_back(16'h8000); press(4'b1000, 1'b0);

    // Timeout in VIEW_A after three ticks
    press(4'b0001, 1'b0); press(4'b0001, 1'b0); check_sc("view_a", 2'b10, 2'b00);
    press(4'b0000, 1'b1); press(4'b0000, 1'b1); check_sc("two_ticks", 2'b10, 2'b00);
    press(4'b0000, 1'b1); check_sc("timeout_fire", 2'b00, 2'b00);
    // Button on terminal tick cancels and restarts the count
    press(4'b0001, 1'b0); press(4'b0001, 1'b0);
    press(4'b0000, 1'b1); press(4'b0000, 1'b1); press(4'b0010, 1'b1);
    check_sc("timeout_blocked", 2'b10, 2'b00);
    press(4'b0000, 1'b1); check_sc("count_restarted", 2'b10, 2'b00);

    // Mode beats Inc in the same cycle: no strobe
    press(4'b0001, 1'b0); press(4'b0001, 1'b0); press(4'b0001, 1'b0);
    check_sc("prio_set_t", 2'b01, 2'b01);
    CT = mk_t(0, 0, 0, 0); press(4'b0101, 1'b0); check_sc("prio_mode", 2'b10, 2'b00);

    // Reset right after an Inc aborts the strobe
    press(4'b0001, 1'b0); press(4'b0001, 1'b0); press(4'b0001, 1'b0);
    @(posedge Clk); #1; BtnInc = 1'b1;
    @(posedge Clk); #1; BtnInc = 1'b0; Clr = 1'b0;
    check_reset_outputs("reset_abort");
    @(negedge Clk); Clr = 1'b1;

    // Back-to-back Inc gives two strobes, each from its own CT sample
    press(4'b0001, 1'b0);
    @(posedge Clk); #1;
    BtnInc = 1'b1; CT = mk_t(4, 8, 2, 3); exp_t_q.push_back(mk_t(4, 8, 2, 4));
    @(posedge Clk); #1;
    CT = mk_t(4, 8, 5, 9); exp_t_q.push_back(mk_t(4, 8, 0, 0));
    @(posedge Clk); #1;
    BtnInc = 1'b0;
    repeat (4) @(negedge Clk);

    checks++;
    if (exp_t_q.size() != 0 || exp_a_q.size() != 0) begin
      errors++;
      $display("FAIL strobes_missing pending_t=%0d pending_a=%0d exp 0",
               exp_t_q.size(), exp_a_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
